// File: rtl/pause_request_arbiter_if.sv
// Pause-and-access handshake bundle between the pause request arbiter and its
// clients / pause handler. The arbiter takes the master modport.
interface pause_request_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic            pause_cpu;
    logic            pause_request;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic            aborted;

    modport master (
        input  req,
        input  done,
        input  pause_cpu,
        output pause_request,
        output grant,
        output busy,
        output aborted
    );

    modport slave (
        output req,
        output done,
        output pause_cpu,
        input  pause_request,
        input  grant,
        input  busy,
        input  aborted
    );
endinterface

// File: rtl/pause_request_arbiter.sv
// Pause request arbiter: halts the CPU via the pause handler, lets in-flight bus
// cycles drain, grants one client exclusive access, then enforces a run hold-off.
module pause_request_arbiter #(
    parameter int NREQ           = 2,
    parameter int SETTLE_CYCLES  = 16,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    pause_request_arbiter_if.master bus
);

    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW_T   = $clog2(TIMEOUT_CYCLES);
    localparam int CW_S   = $clog2(SETTLE_CYCLES);
    localparam int CW_H   = $clog2(HOLDOFF_CYCLES);
    localparam int CW_TS  = (CW_T > CW_S) ? CW_T : CW_S;
    localparam int CW_MAX = (CW_TS > CW_H) ? CW_TS : CW_H;
    localparam int CW     = (CW_MAX > 0) ? CW_MAX : 1;

    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLDOFF_LAST = CW'(HOLDOFF_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQUEST = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_GRANT   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   winner_q, winner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            pause_request_q, pause_request_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            aborted_q, aborted_d;

    logic [IW-1:0]   pick;
    logic            pick_valid;
    logic [IW-1:0]   next_ptr;

    // Round-robin search; ptr_q holds (last_granted + 1) mod NREQ.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        idx        = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!pick_valid && bus.req[idx]) begin
                pick       = IW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    assign next_ptr = (int'(winner_q) >= NREQ - 1) ? '0 : winner_q + IW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        winner_d  = winner_q;
        ptr_d     = ptr_q;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    winner_d = pick;
                    state_d  = S_REQUEST;
                    cnt_d    = '0;
                end
            end
            S_REQUEST: begin
                if (bus.pause_cpu) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    aborted_d = 1'b1;
                    state_d   = S_RELEASE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (!bus.pause_cpu) begin
                    aborted_d = 1'b1;
                    state_d   = S_RELEASE;
                    cnt_d     = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_GRANT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GRANT: begin
                // done wins over a simultaneous pause drop: that is a clean completion.
                if (bus.done[winner_q]) begin
                    ptr_d   = next_ptr;
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (!bus.pause_cpu) begin
                    aborted_d = 1'b1;
                    ptr_d     = next_ptr;
                    state_d   = S_RELEASE;
                    cnt_d     = '0;
                end
            end
            S_RELEASE: begin
                if (cnt_q == HOLDOFF_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change only on clk_sys edges.
    always_comb begin
        pause_request_d = (state_d == S_REQUEST) || (state_d == S_SETTLE) || (state_d == S_GRANT);
        busy_d          = (state_d != S_IDLE);
        grant_d         = '0;
        if (state_d == S_GRANT) begin
            grant_d[winner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            winner_q        <= '0;
            ptr_q           <= '0;
            pause_request_q <= 1'b0;
            grant_q         <= '0;
            busy_q          <= 1'b0;
            aborted_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            winner_q        <= winner_d;
            ptr_q           <= ptr_d;
            pause_request_q <= pause_request_d;
            grant_q         <= grant_d;
            busy_q          <= busy_d;
            aborted_q       <= aborted_d;
        end
    end

    assign bus.pause_request = pause_request_q;
    assign bus.grant         = grant_q;
    assign bus.busy          = busy_q;
    assign bus.aborted       = aborted_q;

endmodule

// File: tb/tb_pause_request_arbiter.sv
// Directed bench for pause_request_arbiter: a round-robin vector table plus
// hand-written sequences for timeout, pause loss, async reset and stray done.
module tb_pause_request_arbiter;

    localparam int NREQ = 2;

    typedef struct {
        logic [1:0] req;
        logic [1:0] exp_grant;
    } vec_t;

    logic clk_sys = 1'b0;
    logic reset;
    logic auto_pause;
    logic pause_man;
    logic [2:0] pdl = '0;
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_sys = ~clk_sys;

    pause_request_arbiter_if #(.NREQ(NREQ)) bus ();

    pause_request_arbiter #(
        .NREQ(NREQ),
        .SETTLE_CYCLES(16),
        .HOLDOFF_CYCLES(256),
        .TIMEOUT_CYCLES(4096)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .bus(bus)
    );

    // Pause handler model: pause_cpu follows pause_request three cycles later.
    always @(posedge clk_sys) pdl <= {pdl[1:0], bus.pause_request};
    assign bus.pause_cpu = auto_pause ? pdl[2] : pause_man;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic reset_dut();
        reset      = 1'b1;
        bus.req    = '0;
        bus.done   = '0;
        pause_man  = 1'b0;
        auto_pause = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // One access: request, pause returned 3 cycles later, grant after settle;
    // with finish set, done 5 cycles into the grant and the full hold-off.
    task automatic do_txn(input logic [1:0] r, input logic [1:0] exp_g,
                          input bit drop, input bit finish, input string nm);
        bus.req = r;
        tick();
        check({nm, " preq rise"}, 32'(bus.pause_request), 32'd1);
        check({nm, " no early grant"}, 32'(bus.grant), 32'd0);
        if (drop) bus.req = '0;
        repeat (3) tick();
        pause_man = 1'b1;
        repeat (16) tick();
        check({nm, " grant after 16"}, 32'(bus.grant), 32'd0);
        tick();
        check({nm, " grant after 17"}, 32'(bus.grant), 32'(exp_g));
        check({nm, " preq in grant"}, 32'(bus.pause_request), 32'd1);
        if (finish) begin
            repeat (5) tick();
            check({nm, " grant held"}, 32'(bus.grant), 32'(exp_g));
            bus.done = exp_g;
            bus.req  = '0;
            tick();
            bus.done = '0;
            check({nm, " grant clear"}, 32'(bus.grant), 32'd0);
            check({nm, " preq clear"}, 32'(bus.pause_request), 32'd0);
            check({nm, " no abort"}, 32'(bus.aborted), 32'd0);
            pause_man = 1'b0;
            repeat (255) tick();
            check({nm, " busy in holdoff"}, 32'(bus.busy), 32'd1);
            tick();
            check({nm, " busy drop"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        vec_t       vecs [7];
        logic [1:0] rr_exp [4];
        int         low_cnt;
        int         waited;
        int         hi;
        int         ab;
        int         gs;

        vecs[0] = '{req: 2'b01, exp_grant: 2'b01};
        vecs[1] = '{req: 2'b11, exp_grant: 2'b10};
        vecs[2] = '{req: 2'b11, exp_grant: 2'b01};
        vecs[3] = '{req: 2'b01, exp_grant: 2'b01};
        vecs[4] = '{req: 2'b10, exp_grant: 2'b10};
        vecs[5] = '{req: 2'b10, exp_grant: 2'b10};
        vecs[6] = '{req: 2'b11, exp_grant: 2'b01};
        rr_exp  = '{2'b01, 2'b10, 2'b01, 2'b10};

        reset      = 1'b1;
        bus.req    = '0;
        bus.done   = '0;
        pause_man  = 1'b0;
        auto_pause = 1'b0;
        tick();
        check("reset grant", 32'(bus.grant), 32'd0);
        check("reset preq", 32'(bus.pause_request), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset aborted", 32'(bus.aborted), 32'd0);

        reset_dut();
        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].req, vecs[i].exp_grant, 1'b0, 1'b1, $sformatf("vec%0d", i));
        end

        // Continuous req=11 with a live pause handler: grants alternate, CPU runs between.
        reset_dut();
        auto_pause = 1'b1;
        bus.req    = 2'b11;
        low_cnt    = 0;
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            while (bus.grant == '0 && waited < 2000) begin
                tick();
                waited++;
                if (!bus.pause_request) low_cnt++;
            end
            check($sformatf("rr grant %0d", g), 32'(bus.grant), 32'(rr_exp[g]));
            if (g > 0) check($sformatf("rr gap %0d ge 257", g), 32'(low_cnt >= 257), 32'd1);
            repeat (5) tick();
            bus.done = rr_exp[g];
            if (g == 3) bus.req = '0;
            tick();
            bus.done = '0;
            low_cnt  = bus.pause_request ? 0 : 1;
        end
        repeat (300) tick();
        check("rr idle", 32'(bus.busy), 32'd0);

        // Timeout: pause never returned.
        reset_dut();
        bus.req = 2'b01;
        hi = 0;
        ab = 0;
        gs = 0;
        for (int i = 0; i < 4300; i++) begin
            tick();
            if (bus.pause_request) hi++;
            if (bus.aborted) ab++;
            if (bus.grant != '0) gs++;
        end
        bus.req = '0;
        check("timeout preq cycles", 32'(hi), 32'd4096);
        check("timeout abort pulses", 32'(ab), 32'd1);
        check("timeout grant cycles", 32'(gs), 32'd0);
        repeat (60) tick();
        check("timeout idle", 32'(bus.busy), 32'd0);

        // Pause lost while granted, then the pointer has moved past client 0.
        reset_dut();
        do_txn(2'b01, 2'b01, 1'b0, 1'b0, "plost");
        pause_man = 1'b0;
        tick();
        check("plost grant", 32'(bus.grant), 32'd0);
        check("plost aborted", 32'(bus.aborted), 32'd1);
        check("plost preq", 32'(bus.pause_request), 32'd0);
        check("plost busy", 32'(bus.busy), 32'd1);
        tick();
        check("plost abort pulse", 32'(bus.aborted), 32'd0);
        repeat (254) tick();
        check("plost holdoff", 32'(bus.busy), 32'd1);
        tick();
        check("plost busy drop", 32'(bus.busy), 32'd0);
        bus.req = '0;
        tick();
        do_txn(2'b11, 2'b10, 1'b0, 1'b1, "plost next");

        // Async reset mid-grant clears outputs without a clock and resets the pointer.
        reset_dut();
        do_txn(2'b01, 2'b01, 1'b0, 1'b1, "arst pre");
        do_txn(2'b01, 2'b01, 1'b0, 1'b0, "arst grant");
        #2;
        reset = 1'b1;
        #1;
        check("arst grant", 32'(bus.grant), 32'd0);
        check("arst preq", 32'(bus.pause_request), 32'd0);
        check("arst busy", 32'(bus.busy), 32'd0);
        check("arst aborted", 32'(bus.aborted), 32'd0);
        bus.req   = '0;
        pause_man = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        do_txn(2'b11, 2'b01, 1'b0, 1'b1, "arst ptr");

        // Dropped req still granted; stray done ignored; done with pause drop is clean.
        reset_dut();
        do_txn(2'b01, 2'b01, 1'b1, 1'b0, "stray");
        bus.done = 2'b10;
        tick();
        bus.done = '0;
        check("stray grant kept", 32'(bus.grant), 32'd1);
        check("stray preq kept", 32'(bus.pause_request), 32'd1);
        check("stray no abort", 32'(bus.aborted), 32'd0);
        bus.done  = 2'b01;
        pause_man = 1'b0;
        tick();
        bus.done = '0;
        check("both grant", 32'(bus.grant), 32'd0);
        check("both preq", 32'(bus.pause_request), 32'd0);
        check("both no abort", 32'(bus.aborted), 32'd0);
        tick();
        check("both no abort later", 32'(bus.aborted), 32'd0);
        repeat (260) tick();
        check("both idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
